// File: rtl/conv2d_stream_param.sv
// Streaming K x K valid-region convolution over an IFM_DIM x IFM_DIM frame.
// Selectable stride 1/2, out_ready backpressure, and a kernel that persists across frames.
module conv2d_stream_param #(
    parameter int DATA_W  = 16,
    parameter int IFM_DIM = 7,
    parameter int K       = 3,
    parameter int ACC_W   = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_ifm,
    input  logic              weight_valid,
    input  logic [DATA_W-1:0] in_weight,
    input  logic              stride_sel,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_ofm,
    output logic              out_last,
    output logic              busy
);

    localparam int NPIX  = IFM_DIM * IFM_DIM;
    localparam int NW    = K * K;
    localparam int PW    = 2 * DATA_W;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int WC_W  = $clog2(NW + 1);
    localparam int WI_W  = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW    = (IFM_DIM > 1) ? $clog2(IFM_DIM) : 1;
    localparam int OD1   = IFM_DIM - K + 1;
    localparam int OD2   = (IFM_DIM - K) / 2 + 1;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DRAIN} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] ifm_buf [NPIX];
    logic [DATA_W-1:0] w_buf   [NW];
    logic [DATA_W-1:0] win_pix [NW];
    logic [DATA_W-1:0] s1_pix  [NW];

    logic [PIX_W-1:0] pix_cnt;
    logic [WC_W-1:0]  w_cnt;
    logic [WI_W-1:0]  w_idx;
    logic             stride_q;
    logic [CW-1:0]    win_r, win_c, last_rc;
    logic             s1_valid, s1_last;
    logic             stall, issue, last_win;
    logic             ifm_accept, frame_start, w_accept;
    logic [ACC_W-1:0] sum;
    logic [PIX_W-1:0] base_r, base_c, rd_idx;

    // A held result freezes every stage behind it, so nothing is lost or duplicated.
    assign stall       = out_valid & ~out_ready;
    assign busy        = (state == CALC) || (state == DRAIN);
    assign ifm_accept  = in_valid & ~busy;
    assign frame_start = ifm_accept & (state == IDLE);
    assign last_rc     = stride_q ? CW'(OD2 - 1) : CW'(OD1 - 1);
    assign last_win    = (win_r == last_rc) && (win_c == last_rc);
    assign issue       = (state == CALC) & ~stall;
    assign w_idx       = frame_start ? '0 : w_cnt[WI_W-1:0];
    assign w_accept    = weight_valid & ~busy & (frame_start | (w_cnt < WC_W'(NW)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = LOAD;
            LOAD:    if (in_valid && (pix_cnt == PIX_W'(NPIX - 1))) state_nxt = CALC;
            CALC:    if (issue && last_win) state_nxt = DRAIN;
            DRAIN:   if (out_valid && out_ready && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame and kernel capture; the weight counter restarts at every frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) ifm_buf[i] <= '0;
            for (int i = 0; i < NW; i++)   w_buf[i]   <= '0;
            pix_cnt  <= '0;
            w_cnt    <= '0;
            stride_q <= 1'b0;
        end else begin
            if (ifm_accept) begin
                ifm_buf[pix_cnt] <= in_ifm;
                pix_cnt <= (pix_cnt == PIX_W'(NPIX - 1)) ? '0 : pix_cnt + 1'b1;
            end
            if (frame_start) stride_q <= stride_sel;
            if (w_accept) w_buf[w_idx] <= in_weight;
            if (frame_start)   w_cnt <= WC_W'(weight_valid);
            else if (w_accept) w_cnt <= w_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r <= '0;
            win_c <= '0;
        end else if (issue) begin
            if (win_c == last_rc) begin
                win_c <= '0;
                win_r <= (win_r == last_rc) ? '0 : win_r + 1'b1;
            end else begin
                win_c <= win_c + 1'b1;
            end
        end
    end

    always_comb begin
        base_r = stride_q ? (PIX_W'(win_r) << 1) : PIX_W'(win_r);
        base_c = stride_q ? (PIX_W'(win_c) << 1) : PIX_W'(win_c);
        rd_idx = '0;
        for (int i = 0; i < NW; i++) win_pix[i] = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                rd_idx = (base_r + PIX_W'(i)) * PIX_W'(IFM_DIM) + base_c + PIX_W'(j);
                win_pix[i*K + j] = ifm_buf[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) s1_pix[i] <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= issue;
            if (issue) begin
                for (int i = 0; i < NW; i++) s1_pix[i] <= win_pix[i];
                s1_last <= last_win;
            end
        end
    end

    // Full-width products, accumulated modulo 2^ACC_W.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NW; i++) begin
            sum = sum + ACC_W'(PW'(s1_pix[i]) * PW'(w_buf[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ofm   <= '0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_ofm  <= sum;
                out_last <= s1_last;
            end else begin
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream_param.sv
// Directed bench for conv2d_stream_param at default geometry (7x7 frame, 3x3 kernel, 16/36 bits).
module tb_conv2d_stream_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, weight_valid, stride_sel, out_ready;
    logic [15:0] in_ifm, in_weight;
    logic        out_valid, out_last, busy;
    logic [35:0] out_ofm;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [15:0] ifm_q [49];
    logic [15:0] w_q   [9];
    logic [63:0] exp_q [25];

    always #5 clk = ~clk;

    conv2d_stream_param #(.DATA_W(16), .IFM_DIM(7), .K(3), .ACC_W(36)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ifm(in_ifm),
        .weight_valid(weight_valid), .in_weight(in_weight),
        .stride_sel(stride_sel), .out_ready(out_ready),
        .out_valid(out_valid), .out_ofm(out_ofm), .out_last(out_last), .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Streams one frame; stride_sel is inverted after the first beat to prove it is latched.
    task automatic applyStimulus(input bit strd, input int nw, input bit gaps);
        for (int i = 0; i < 49; i++) begin
            if (gaps && (i % 7 == 3)) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                weight_valid = 1'b0;
            end
            @(posedge clk); #1;
            in_valid     = 1'b1;
            in_ifm       = ifm_q[i];
            weight_valid = (i < nw);
            in_weight    = (i < 9) ? w_q[i] : 16'h0000;
            stride_sel   = (i == 0) ? strd : ~strd;
        end
        @(posedge clk); #1;
        in_valid     = 1'b0;
        weight_valid = 1'b0;
    endtask

    task automatic collectResults(input int n_exp, input int stall_at, input int reset_at, input bit noise);
        int got = 0;
        int cyc = 0;
        int first = -1;
        int stalls = 0;
        int extra = 0;
        bit aborted = 1'b0;
        while (got < n_exp && cyc < 300 && !aborted) begin
            @(negedge clk);
            if (noise) begin
                in_valid     = (got < 20);
                weight_valid = (got < 20);
                in_ifm       = 16'h1234;
                in_weight    = 16'h0007;
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (got == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("rst_valid", 64'(out_valid), 64'd0);
                    checkOutput("rst_ofm",   64'(out_ofm),   64'd0);
                    checkOutput("rst_last",  64'(out_last),  64'd0);
                    checkOutput("rst_busy",  64'(busy),      64'd0);
                    aborted = 1'b1;
                end else if (got == stall_at && stalls < 3) begin
                    out_ready = 1'b0;
                    stalls++;
                    checkOutput("held_ofm",  64'(out_ofm),  exp_q[got]);
                    checkOutput("held_last", 64'(out_last), 64'd0);
                end else begin
                    out_ready = 1'b1;
                    checkOutput($sformatf("ofm[%0d]", got), 64'(out_ofm), exp_q[got]);
                    checkOutput($sformatf("last[%0d]", got), 64'(out_last), 64'(got == n_exp - 1));
                    got++;
                end
            end else begin
                out_ready = 1'b1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        weight_valid = 1'b0;
        out_ready = 1'b1;
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end else begin
            checkOutput("count",   64'(got),   64'(n_exp));
            checkOutput("latency", 64'(first), 64'd2);
            repeat (4) begin
                @(negedge clk);
                if (out_valid) extra++;
            end
            checkOutput("extra_valid", 64'(extra), 64'd0);
            checkOutput("busy_end",    64'(busy),  64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; weight_valid = 1'b0;
        in_ifm = '0; in_weight = '0;
        stride_sel = 1'b0; out_ready = 1'b1;
        #12;
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_ofm",   64'(out_ofm),   64'd0);
        checkOutput("reset_last",  64'(out_last),  64'd0);
        checkOutput("reset_busy",  64'(busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] ones, stride 1");
        for (int i = 0; i < 49; i++) ifm_q[i] = 16'd1;
        for (int i = 0; i < 9; i++)  w_q[i]   = 16'd1;
        for (int i = 0; i < 25; i++) exp_q[i] = 64'd9;
        applyStimulus(1'b0, 9, 1'b0);
        collectResults(25, -1, -1, 1'b0);

        $display("[TB] ramp, stride 1, gapped input");
        for (int i = 0; i < 49; i++) ifm_q[i] = 16'(i);
        for (int i = 0; i < 9; i++)  w_q[i]   = (i == 4) ? 16'd1 : 16'd0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) exp_q[r*5 + c] = 64'(7*r + c + 8);
        applyStimulus(1'b0, 9, 1'b1);
        collectResults(25, -1, -1, 1'b0);

        $display("[TB] ramp, stride 2, kernel reused");
        exp_q[0] = 64'd8;  exp_q[1] = 64'd10; exp_q[2] = 64'd12;
        exp_q[3] = 64'd22; exp_q[4] = 64'd24; exp_q[5] = 64'd26;
        exp_q[6] = 64'd36; exp_q[7] = 64'd38; exp_q[8] = 64'd40;
        applyStimulus(1'b1, 0, 1'b0);
        collectResults(9, -1, -1, 1'b0);

        $display("[TB] backpressure on 5th result, beats while busy");
        for (int i = 0; i < 49; i++) ifm_q[i] = 16'd1;
        for (int i = 0; i < 9; i++)  w_q[i]   = 16'd1;
        for (int i = 0; i < 25; i++) exp_q[i] = 64'd9;
        applyStimulus(1'b0, 9, 1'b0);
        collectResults(25, 4, -1, 1'b1);

        $display("[TB] max values, extra weight beats");
        for (int i = 0; i < 49; i++) ifm_q[i] = 16'hFFFF;
        for (int i = 0; i < 9; i++)  w_q[i]   = 16'hFFFF;
        for (int i = 0; i < 25; i++) exp_q[i] = 64'h8_FFEE_0009;
        applyStimulus(1'b0, 12, 1'b0);
        collectResults(25, -1, -1, 1'b0);

        $display("[TB] persistent max kernel, ones frame");
        for (int i = 0; i < 49; i++) ifm_q[i] = 16'd1;
        for (int i = 0; i < 25; i++) exp_q[i] = 64'h8_FFF7;
        applyStimulus(1'b0, 0, 1'b0);
        collectResults(25, -1, -1, 1'b0);

        $display("[TB] reset at 10th result");
        for (int i = 0; i < 9; i++)  w_q[i]   = 16'd1;
        for (int i = 0; i < 25; i++) exp_q[i] = 64'd9;
        applyStimulus(1'b0, 9, 1'b0);
        collectResults(25, -1, 9, 1'b0);

        $display("[TB] post-reset kernel is zero");
        for (int i = 0; i < 25; i++) exp_q[i] = 64'd0;
        applyStimulus(1'b0, 0, 1'b0);
        collectResults(25, -1, -1, 1'b0);

        $display("[TB] post-reset fresh weights");
        for (int i = 0; i < 25; i++) exp_q[i] = 64'd9;
        applyStimulus(1'b0, 9, 1'b0);
        collectResults(25, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
